hazard_forward_ctrl: RTL and testbench

//  Parametrised forwarding and hazard controller for the pipelined core.

---
 rtl/hazard_forward_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_hazard_forward_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_forward_ctrl.sv
// hazard_forward_ctrl: EX operand forwarding select and load-use / memory-wait pipeline control.
// Latency: fwd_sel and all controls are combinational from inputs and current state; state moves on clk.
// Backpressure: mem_req && !mem_ready freezes the pipeline (hold_all) for at most MEM_TIMEOUT cycles.
// Optional feature: define HAZARD_PERF_CNT_EN to add perf_lu_cycles / perf_mem_cycles counters.
module hazard_forward_ctrl #(
    parameter int NUM_SRC        = 2,
    parameter int NUM_FWD_STAGES = 2,
    parameter int REG_ADDR_W     = 5,
    parameter int LOAD_LAT       = 1,
    parameter int MEM_TIMEOUT    = 16,
    localparam int SEL_W         = $clog2(NUM_FWD_STAGES + 1)
) (
    input  logic                                 clk,
    input  logic                                 arst_n,
    input  logic [NUM_SRC*REG_ADDR_W-1:0]        ex_rs,
    input  logic [NUM_SRC*REG_ADDR_W-1:0]        id_rs,
    input  logic [NUM_SRC-1:0]                   id_rs_used,
    input  logic                                 ex_mem_read,
    input  logic [REG_ADDR_W-1:0]                ex_rd,
    input  logic [NUM_FWD_STAGES*REG_ADDR_W-1:0] fwd_rd,
    input  logic [NUM_FWD_STAGES-1:0]            fwd_we,
    input  logic                                 mem_req,
    input  logic                                 mem_ready,
    output logic [NUM_SRC*SEL_W-1:0]             fwd_sel,
    output logic                                 stall_if_id,
    output logic                                 bubble_id_ex,
    output logic                                 hold_all,
    output logic                                 mem_timeout
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]                          perf_lu_cycles,
    output logic [31:0]                          perf_mem_cycles
`endif
);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_LU_STALL = 2'd1;
    localparam logic [1:0] ST_MEM_WAIT = 2'd2;

    localparam int LU_W   = (LOAD_LAT > 1) ? $clog2(LOAD_LAT + 1) : 1;
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    localparam logic [LU_W-1:0]   LU_INIT  = LU_W'(LOAD_LAT - 1);
    localparam logic [LU_W-1:0]   LU_ONE   = LU_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

    logic [1:0]            state, state_nxt;
    logic [1:0]            prev_state, prev_nxt;
    logic [LU_W-1:0]       lu_cnt, lu_cnt_nxt;
    logic [WAIT_W-1:0]     wait_cnt, wait_nxt;
    logic                  timeout_set;
    logic                  lu_hit;
    logic                  mem_stall;
    logic                  stall_raw, bubble_raw, hold_raw;
    logic [REG_ADDR_W-1:0] rs_cur;

    assign mem_stall = mem_req && !mem_ready;

    // Forwarding select per source; stages scanned oldest to youngest so the youngest match wins.
    always_comb begin
        fwd_sel = '0;
        rs_cur  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            rs_cur = ex_rs[i*REG_ADDR_W +: REG_ADDR_W];
            for (int k = NUM_FWD_STAGES - 1; k >= 0; k--) begin
                if (fwd_we[k] && (fwd_rd[k*REG_ADDR_W +: REG_ADDR_W] == rs_cur) && (rs_cur != '0)) begin
                    fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(k + 1);
                end
            end
        end
    end

    // Load-use detection: a load in EX writes a register that ID actually reads (x0 never hazards).
    always_comb begin
        lu_hit = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (id_rs_used[i] && (id_rs[i*REG_ADDR_W +: REG_ADDR_W] == ex_rd)) begin
                lu_hit = 1'b1;
            end
        end
        lu_hit = lu_hit && ex_mem_read && (ex_rd != '0);
    end

    // Next-state and raw control decode; a memory stall always beats the load-use logic.
    always_comb begin
        state_nxt   = state;
        prev_nxt    = prev_state;
        lu_cnt_nxt  = lu_cnt;
        wait_nxt    = wait_cnt;
        timeout_set = 1'b0;
        stall_raw   = 1'b0;
        bubble_raw  = 1'b0;
        hold_raw    = 1'b0;
        case (state)
            ST_RUN: begin
                if (mem_stall) begin
                    hold_raw  = 1'b1;
                    prev_nxt  = ST_RUN;
                    wait_nxt  = WAIT_ONE;
                    state_nxt = ST_MEM_WAIT;
                end else if (lu_hit) begin
                    stall_raw  = 1'b1;
                    bubble_raw = 1'b1;
                    if (LOAD_LAT > 1) begin
                        lu_cnt_nxt = LU_INIT;
                        state_nxt  = ST_LU_STALL;
                    end
                end
            end
            ST_LU_STALL: begin
                if (mem_stall) begin
                    hold_raw  = 1'b1;
                    prev_nxt  = ST_LU_STALL;
                    wait_nxt  = WAIT_ONE;
                    state_nxt = ST_MEM_WAIT;
                end else begin
                    stall_raw  = 1'b1;
                    bubble_raw = 1'b1;
                    lu_cnt_nxt = lu_cnt - LU_ONE;
                    if (lu_cnt == LU_ONE) begin
                        state_nxt = ST_RUN;
                    end
                end
            end
            ST_MEM_WAIT: begin
                // The release cycle (ready or timeout) lets the pipeline advance once before resuming.
                if (mem_ready) begin
                    state_nxt = prev_state;
                end else if (wait_cnt < WAIT_MAX) begin
                    hold_raw = 1'b1;
                    wait_nxt = wait_cnt + WAIT_ONE;
                end else begin
                    timeout_set = 1'b1;
                    state_nxt   = prev_state;
                end
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    // Controls are forced low while reset is asserted so a mid-stall reset aborts immediately.
    assign stall_if_id  = stall_raw  && arst_n;
    assign bubble_id_ex = bubble_raw && arst_n;
    assign hold_all     = hold_raw   && arst_n;

    // FSM state, counters and the sticky timeout flag.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state       <= ST_RUN;
            prev_state  <= ST_RUN;
            lu_cnt      <= '0;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            prev_state  <= prev_nxt;
            lu_cnt      <= lu_cnt_nxt;
            wait_cnt    <= wait_nxt;
            mem_timeout <= mem_timeout | timeout_set;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // Saturating event counters for bubble and freeze cycles.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            perf_lu_cycles  <= '0;
            perf_mem_cycles <= '0;
        end else begin
            if (bubble_id_ex && (perf_lu_cycles != 32'hFFFF_FFFF)) begin
                perf_lu_cycles <= perf_lu_cycles + 32'd1;
            end
            if (hold_all && (perf_mem_cycles != 32'hFFFF_FFFF)) begin
                perf_mem_cycles <= perf_mem_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// tb_hazard_forward_ctrl: directed and random checks of forwarding, load-use bubbles and memory waits.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Expected values are queued as stimulus is driven and popped when the outputs are sampled.
module tb_hazard_forward_ctrl;

    logic        clk;
    logic        arst_n;
    logic [9:0]  ex_rs;
    logic [9:0]  id_rs;
    logic [1:0]  id_rs_used;
    logic        ex_mem_read;
    logic [4:0]  ex_rd;
    logic [9:0]  fwd_rd;
    logic [1:0]  fwd_we;
    logic        mem_req;
    logic        mem_ready;
    logic [3:0]  fwd_sel;
    logic        stall_if_id;
    logic        bubble_id_ex;
    logic        hold_all;
    logic        mem_timeout;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_lu_cycles;
    logic [31:0] perf_mem_cycles;
`endif

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_ctl_q[$];
    logic [3:0] exp_fwd_q[$];

    hazard_forward_ctrl #(
        .NUM_SRC(2), .NUM_FWD_STAGES(2), .REG_ADDR_W(5), .LOAD_LAT(3), .MEM_TIMEOUT(16)
    ) dut (
        .clk(clk), .arst_n(arst_n), .ex_rs(ex_rs), .id_rs(id_rs), .id_rs_used(id_rs_used),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .fwd_rd(fwd_rd), .fwd_we(fwd_we),
        .mem_req(mem_req), .mem_ready(mem_ready), .fwd_sel(fwd_sel), .stall_if_id(stall_if_id),
        .bubble_id_ex(bubble_id_ex), .hold_all(hold_all), .mem_timeout(mem_timeout)
`ifdef HAZARD_PERF_CNT_EN
        , .perf_lu_cycles(perf_lu_cycles), .perf_mem_cycles(perf_mem_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    // Reference forwarding select: lowest stage index with a write to the same non-zero register.
    function automatic logic [3:0] fwd_model(input logic [9:0] rs, input logic [9:0] rd, input logic [1:0] we);
        logic [3:0] sel;
        logic [4:0] r;
        logic       found;
        sel = '0;
        for (int s = 0; s < 2; s++) begin
            r = rs[s*5 +: 5];
            found = 1'b0;
            for (int k = 0; k < 2; k++) begin
                if (!found && we[k] && rd[k*5 +: 5] == r && r != 5'd0) begin
                    sel[s*2 +: 2] = 2'(k + 1);
                    found = 1'b1;
                end
            end
        end
        return sel;
    endfunction

    task automatic idle_inputs();
        ex_rs = '0; id_rs = '0; id_rs_used = '0; ex_mem_read = 1'b0; ex_rd = '0;
        fwd_rd = '0; fwd_we = '0; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] exp, obs;
        arst_n = 1'b0;
        idle_inputs();
        // Hazard-provoking inputs must not leak through while reset is held.
        ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs = {5'd0, 5'd7}; id_rs_used = 2'b01;
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            exp_ctl_q.push_back(4'b0000);
            @(negedge clk);
            exp = exp_ctl_q.pop_front();
            obs = {stall_if_id, bubble_id_ex, hold_all, mem_timeout};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL reset_hold[%0d]: got %b, required %b", c, obs, exp);
            end
        end
        next_cycle();
        idle_inputs();
        arst_n = 1'b1;
        exp_ctl_q.push_back(4'b0000);
        @(negedge clk);
        exp = exp_ctl_q.pop_front();
        obs = {stall_if_id, bubble_id_ex, hold_all, mem_timeout};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL reset_release: got %b, required %b", obs, exp);
        end
    endtask

    task automatic test_fwd_directed();
        // {ex_rs, fwd_rd, fwd_we, expected fwd_sel}; packing is {src1, src0} and {stage1, stage0}.
        logic [25:0] vec [6];
        logic [3:0]  exp;
        vec[0] = {5'd5, 5'd5, 5'd5, 5'd5, 2'b11, 4'b0101};
        vec[1] = {5'd0, 5'd0, 5'd0, 5'd0, 2'b11, 4'b0000};
        vec[2] = {5'd3, 5'd5, 5'd3, 5'd5, 2'b11, 4'b1001};
        vec[3] = {5'd3, 5'd5, 5'd3, 5'd5, 2'b01, 4'b0001};
        vec[4] = {5'd5, 5'd5, 5'd5, 5'd5, 2'b10, 4'b1010};
        vec[5] = {5'd5, 5'd5, 5'd5, 5'd5, 2'b00, 4'b0000};
        for (int v = 0; v < 6; v++) begin
            next_cycle();
            ex_rs  = vec[v][25:16];
            fwd_rd = vec[v][15:6];
            fwd_we = vec[v][5:4];
            exp_fwd_q.push_back(vec[v][3:0]);
            @(negedge clk);
            exp = exp_fwd_q.pop_front();
            checks++;
            if (fwd_sel !== exp) begin
                errors++;
                $display("FAIL fwd_directed[%0d]: got %b, required %b", v, fwd_sel, exp);
            end
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_fwd_random();
        logic [3:0] exp;
        for (int n = 0; n < 24; n++) begin
            next_cycle();
            ex_rs  = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            fwd_rd = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            fwd_we = 2'($urandom_range(0, 3));
            exp_fwd_q.push_back(fwd_model(ex_rs, fwd_rd, fwd_we));
            @(negedge clk);
            exp = exp_fwd_q.pop_front();
            checks++;
            if (fwd_sel !== exp) begin
                errors++;
                $display("FAIL fwd_random[%0d]: got %b, required %b (rs=%h rd=%h we=%b)",
                         n, fwd_sel, exp, ex_rs, fwd_rd, fwd_we);
            end
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_load_use();
        logic [3:0] exp, obs;
        // Near misses: x0 destination, unused source, non-load instruction.
        logic [21:0] neg [3];   // {ex_mem_read, ex_rd, id_rs, id_rs_used, pad4}
        neg[0] = {1'b1, 5'd0, 5'd0, 5'd0, 2'b11, 4'h0};
        neg[1] = {1'b1, 5'd7, 5'd7, 5'd7, 2'b00, 4'h0};
        neg[2] = {1'b0, 5'd7, 5'd7, 5'd7, 2'b11, 4'h0};
        for (int v = 0; v < 3; v++) begin
            next_cycle();
            ex_mem_read = neg[v][21];
            ex_rd       = neg[v][20:16];
            id_rs       = neg[v][15:6];
            id_rs_used  = neg[v][5:4];
            exp_ctl_q.push_back(4'b0000);
            @(negedge clk);
            exp = exp_ctl_q.pop_front();
            obs = {stall_if_id, bubble_id_ex, hold_all, mem_timeout};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL lu_nohit[%0d]: got %b, required %b", v, obs, exp);
            end
        end
        // Real hazards through src0 then src1: exactly LOAD_LAT = 3 bubbles each.
        for (int s = 0; s < 2; s++) begin
            for (int c = 0; c < 5; c++) begin
                next_cycle();
                idle_inputs();
                if (c == 0) begin
                    ex_mem_read = 1'b1;
                    ex_rd       = 5'd7;
                    id_rs       = (s == 0) ? {5'd2, 5'd7} : {5'd7, 5'd2};
                    id_rs_used  = (s == 0) ? 2'b01 : 2'b10;
                end
                exp_ctl_q.push_back((c < 3) ? 4'b1100 : 4'b0000);
                @(negedge clk);
                exp = exp_ctl_q.pop_front();
                obs = {stall_if_id, bubble_id_ex, hold_all, mem_timeout};
                checks++;
                if (obs !== exp) begin
                    errors++;
                    $display("FAIL lu_bubble src%0d cyc%0d: got %b, required %b", s, c, obs, exp);
                end
            end
        end
    endtask

    task automatic test_mem_wait();
        logic [3:0] exp, obs;
        for (int c = 0; c < 6; c++) begin
            next_cycle();
            mem_req   = (c < 5);
            mem_ready = (c == 4);
            exp_ctl_q.push_back((c < 4) ? 4'b0010 : 4'b0000);
            @(negedge clk);
            exp = exp_ctl_q.pop_front();
            obs = {stall_if_id, bubble_id_ex, hold_all, mem_timeout};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL mem_wait cyc%0d: got %b, required %b", c, obs, exp);
            end
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_lu_mem_reset();
        logic [3:0] exp, obs;
        // Per cycle {ex_mem_read, mem_req, mem_ready, expected}.
        logic [6:0] seq [7];
        seq[0] = {3'b100, 4'b1100};
        seq[1] = {3'b010, 4'b0010};
        seq[2] = {3'b010, 4'b0010};
        seq[3] = {3'b011, 4'b0000};
        seq[4] = {3'b000, 4'b1100};
        seq[5] = {3'b000, 4'b1100};
        seq[6] = {3'b000, 4'b0000};
        for (int c = 0; c < 7; c++) begin
            next_cycle();
            ex_rd = 5'd7; id_rs = {5'd0, 5'd7}; id_rs_used = 2'b01;
            ex_mem_read = seq[c][6];
            mem_req     = seq[c][5];
            mem_ready   = seq[c][4];
            exp_ctl_q.push_back(seq[c][3:0]);
            @(negedge clk);
            exp = exp_ctl_q.pop_front();
            obs = {stall_if_id, bubble_id_ex, hold_all, mem_timeout};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL lu_mem cyc%0d: got %b, required %b", c, obs, exp);
            end
        end
        // Start a new hazard, then reset during its second bubble.
        next_cycle();
        ex_mem_read = 1'b1;
        next_cycle();
        ex_mem_read = 1'b0;
        #1;
        arst_n = 1'b0;
        exp_ctl_q.push_back(4'b0000);
        #1;
        exp = exp_ctl_q.pop_front();
        obs = {stall_if_id, bubble_id_ex, hold_all, mem_timeout};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL reset_mid_stall: got %b, required %b", obs, exp);
        end
        next_cycle();
        idle_inputs();
        arst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            exp_ctl_q.push_back(4'b0000);
            @(negedge clk);
            exp = exp_ctl_q.pop_front();
            obs = {stall_if_id, bubble_id_ex, hold_all, mem_timeout};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL post_reset_residual[%0d]: got %b, required %b", c, obs, exp);
            end
            next_cycle();
        end
    endtask

    task automatic test_timeout();
        logic [3:0] exp, obs;
        logic [4:0] hold_run;
        hold_run = '0;
        // 16 hold cycles, one release cycle, then the sticky flag with the request withdrawn.
        for (int c = 0; c < 21; c++) begin
            if (c > 0) next_cycle();
            mem_req   = (c < 17);
            mem_ready = 1'b0;
            if (c < 16)       exp_ctl_q.push_back(4'b0010);
            else if (c == 16) exp_ctl_q.push_back(4'b0000);
            else              exp_ctl_q.push_back(4'b0001);
            @(negedge clk);
            exp = exp_ctl_q.pop_front();
            obs = {stall_if_id, bubble_id_ex, hold_all, mem_timeout};
            if (hold_all === 1'b1) hold_run++;
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL timeout cyc%0d: got %b, required %b", c, obs, exp);
            end
        end
        checks++;
        if (hold_run !== 5'd16) begin
            errors++;
            $display("FAIL timeout_hold_count: got %0d, required 16", hold_run);
        end
        next_cycle();
        idle_inputs();
        arst_n = 1'b0;
        #1;
        checks++;
        if (mem_timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_clear_on_reset: got %b, required 0", mem_timeout);
        end
        next_cycle();
        arst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_fwd_directed();
        test_fwd_random();
        test_load_use();
        test_mem_wait();
        test_lu_mem_reset();
        next_cycle();
        test_timeout();
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
